program_ram: RTL
================

# program_ram

Parametrised program memory for the CPU core, the successor to the fixed 256×12 hardcoded program RAM. It has a single-clock CPU read/write port with a registered read. A built-in sequencer can clear the whole array after reset. A valid/ready loader port streams a program image into any address window at runtime and holds the CPU while it does so.

## Interface
Parameters:
- ADDR_WIDTH, 8, address bits; depth = 2^ADDR_WIDTH words
- DATA_WIDTH, 12, word width
- CLEAR_ON_RESET, 1, 1 = clear the array after reset; 0 = skip the clear
- CLEAR_VALUE, 0, DATA_WIDTH-bit value written during the clear

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- cpu_addr  in  ADDR_WIDTH  CPU read/write address
- cpu_din  in  DATA_WIDTH  CPU write data
- cpu_write_en  in  1  CPU write strobe
- cpu_dout  out  DATA_WIDTH  registered read data
- cpu_hold  out  1  CPU must stall; equals busy
- busy  out  1  sequencer is in CLEAR or LOAD
- load_start  in  1  one-cycle request to begin a load
- load_base  in  ADDR_WIDTH  first load address, sampled on an accepted load_start
- load_count  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH, sampled on an accepted load_start
- load_valid  in  1  load_data is valid
- load_data  in  DATA_WIDTH  loader word
- load_ready  out  1  loader word accepted when valid & ready
- load_done  out  1  one-cycle pulse when a load finishes

## Operation
- Sequencer states:
  - CLEAR: one counter-addressed write of CLEAR_VALUE per cycle, address 0 → 2^ADDR_WIDTH−1, then IDLE.
  - IDLE: the CPU port is live.
  - LOAD: streams loader words into the array, then IDLE.
- Reset:
  - State → CLEAR if CLEAR_ON_RESET, else IDLE.
  - Counters → 0; cpu_dout → 0; load_done → 0.
- Outputs after reset (combinational from state):
  - busy and cpu_hold = CLEAR_ON_RESET.
  - load_ready = 0.
- Reset asserted mid-CLEAR or mid-LOAD aborts the operation. Words already written are kept, unless the following CLEAR overwrites them.
- IDLE:
  - cpu_write_en writes mem[cpu_addr] ← cpu_din.
  - cpu_dout ← mem[cpu_addr] every cycle, read-before-write: a simultaneous write to the same address returns the old word.
- load_start accepted only in IDLE:
  - Captures load_base and load_count; index ← 0.
  - load_count = 0: stay in IDLE and pulse load_done the next cycle.
  - load_count ≠ 0: enter LOAD.
- load_start in CLEAR or LOAD is ignored and not queued.
- Same-cycle load_start and cpu_write_en in IDLE: the CPU write completes, and the load starts on the same edge.
- LOAD:
  - load_ready = 1.
  - Each valid & ready cycle writes mem[(load_base + index) mod 2^ADDR_WIDTH] ← load_data and increments index. The address wraps past the top of the array to 0.
  - When the accepted word is number load_count: state → IDLE and load_done pulses for one cycle.
  - load_valid low simply stalls; there is no timeout.
  - load_count = 2^ADDR_WIDTH rewrites the whole array.
- CLEAR and LOAD:
  - cpu_write_en is ignored.
  - cpu_dout holds its last value.
  - The loader port is not ready during CLEAR.

## Timing
- CPU read latency: 1 cycle; address at edge N, data valid after edge N.
- CPU write: visible to a read issued on the following cycle.
- Clear: the first clear write happens on the first edge with reset low. busy drops after exactly 2^ADDR_WIDTH clear edges (256 for defaults).
- Load start: load_start at edge N → load_ready high from edge N+1.
- Load throughput: one word per cycle at full rate, so load_count words take load_count cycles of load_valid.
- Load end:
  - The last word is accepted at edge M.
  - After M: load_ready = 0, busy = 0, load_done = 1.
  - After M+1: load_done = 0.
  - CPU access resumes in the cycle after M.
- There is no combinational path from load_valid to load_ready.

## Test plan
- Reset clear: CLEAR_ON_RESET=1, CLEAR_VALUE=12'hCFF, 1-cycle reset → busy high for 256 cycles; then read addresses 0, 127, 255 → 12'hCFF each, 1-cycle latency.
- CPU port: write 12'h9D1 @0 and 12'hD05 @1, read back both → 12'h9D1, 12'hD05. Same-cycle read+write of @0 with 12'h5A1 → returns 12'h9D1, and the next read returns 12'h5A1.
- Wrapping load: load_base=8'hFE, load_count=4, data 12'h111..12'h444 with load_valid gapped on alternate cycles → @FE=111, @FF=222, @00=333, @01=444; load_done pulses once, 1 cycle after the 4th accept; cpu_write_en during the load has no effect.
- Zero-count load: load_start with load_count=0 → busy never rises; load_done pulses the cycle after; memory unchanged.
- Ignored start and mid-load reset:
  - load_start during CLEAR → no load occurs.
  - Reset after 2 of 5 load words with CLEAR_ON_RESET=0 → busy=0 and load_ready=0 after the reset edge; the 2 written words persist and the rest are unchanged.
- Full-depth load: load_count=256, base=0x10, data = index → mem[(0x10+i) mod 256] = i for all i; busy is high for exactly 256 accepted cycles.

Source files
------------

// File: rtl/program_ram_if.sv
// Bus bundle for program_ram: CPU read/write port, loader stream port and status.
//   master : CPU/loader side (drives addresses, data, strobes; sees dout/status)
//   slave  : memory side
interface program_ram_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_din;
  logic                  cpu_write_en;
  logic [DATA_WIDTH-1:0] cpu_dout;
  logic                  cpu_hold;
  logic                  busy;
  logic                  load_start;
  logic [ADDR_WIDTH-1:0] load_base;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_done;

  modport master (
    output cpu_addr, cpu_din, cpu_write_en, load_start, load_base, load_count, load_valid,
           load_data,
    input  cpu_dout, cpu_hold, busy, load_ready, load_done
  );

  modport slave (
    input  cpu_addr, cpu_din, cpu_write_en, load_start, load_base, load_count, load_valid,
           load_data,
    output cpu_dout, cpu_hold, busy, load_ready, load_done
  );
endinterface

// File: rtl/program_ram.sv
// Parametrised single-clock program memory.
//   clk, reset : clock and synchronous active-high reset
//   bus        : program_ram_if.slave
//     cpu_*    : CPU read/write port, registered read (read-before-write)
//     load_*   : valid/ready loader that streams words into a wrapping address window
//     busy     : sequencer in clear or load; cpu_hold mirrors it
// After reset the sequencer optionally clears the whole array, one word per cycle.
module program_ram #(
  parameter int unsigned          ADDR_WIDTH     = 8,
  parameter int unsigned          DATA_WIDTH     = 12,
  parameter bit                   CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input logic          clk,
  input logic          reset,
  program_ram_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StClear, StIdle, StLoad} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   index_q, index_d;
  logic [ADDR_WIDTH:0]   index_inc;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] dout_q;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    base_d    = base_q;
    count_d   = count_q;
    index_d   = index_q;
    done_d    = 1'b0;
    we        = 1'b0;
    waddr     = bus.cpu_addr;
    wdata     = bus.cpu_din;
    index_inc = index_q + 1'b1;

    unique case (state_q)
      StClear: begin
        we    = 1'b1;
        waddr = clr_q;
        wdata = CLEAR_VALUE;
        clr_d = clr_q + 1'b1;
        if (&clr_q) state_d = StIdle;
      end
      StIdle: begin
        we = bus.cpu_write_en;
        if (bus.load_start) begin
          base_d  = bus.load_base;
          count_d = bus.load_count;
          index_d = '0;
          // An empty load completes immediately without leaving idle.
          if (bus.load_count == '0) done_d = 1'b1;
          else                      state_d = StLoad;
        end
      end
      StLoad: begin
        // Address wraps naturally through the ADDR_WIDTH-bit sum.
        waddr = base_q + index_q[ADDR_WIDTH-1:0];
        wdata = bus.load_data;
        if (bus.load_valid) begin
          we      = 1'b1;
          index_d = index_inc;
          if (index_inc == count_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? StClear : StIdle;
      clr_q   <= '0;
      base_q  <= '0;
      count_q <= '0;
      index_q <= '0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      base_q  <= base_d;
      count_q <= count_d;
      index_q <= index_d;
      done_q  <= done_d;
      // Read uses the pre-edge array contents, so a same-address write returns the old word.
      if (state_q == StIdle) dout_q <= mem[bus.cpu_addr];
    end
  end

  // Reset aborts any in-flight clear/load write on the reset edge itself.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wdata;
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.cpu_hold   = bus.busy;
  assign bus.load_ready = (state_q == StLoad);
  assign bus.load_done  = done_q;
  assign bus.cpu_dout   = dout_q;
endmodule
